// File: rtl/decode_queue_stage.sv
// Instruction buffer FIFO feeding a registered ID/EX control stage.
// Decodes the FIFO head, stalls on load-use hazards, supports flush and commit ordering.
module decode_queue_stage #(
    parameter int QDEPTH  = 4,
    parameter int ILEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      f_valid,
    input  logic [ILEN-1:0]           f_instr,
    output logic                      f_ready,
    input  logic                      flush,
    input  logic                      ex_ready,
    output logic                      ex_valid,
    output logic [ILEN-1:0]           ex_instr,
    output logic [4:0]                ex_rs1,
    output logic [4:0]                ex_rs2,
    output logic [4:0]                ex_rd,
    output logic [2:0]                ex_funct3,
    output logic [6:0]                ex_funct7,
    output logic                      ex_regwrite,
    output logic                      ex_memread,
    output logic                      ex_memwrite,
    output logic                      ex_alu_select,
    output logic                      ex_wb_src,
    output logic                      ex_unsign,
    output logic                      ex_commit,
    output logic [ORDER_W-1:0]        ex_order,
    output logic [$clog2(QDEPTH):0]   count
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic               valid;
        logic [ILEN-1:0]    instr;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               alu_select;
        logic               wb_src;
        logic               unsign;
        logic               commit;
        logic [ORDER_W-1:0] order;
    } idex_t;

    logic [ILEN-1:0]    mem_q [QDEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [ORDER_W-1:0] order_q, order_d;
    idex_t              ex_q, ex_d, dec;

    logic [ILEN-1:0] head;
    logic            empty, full, uses_rs2, legal, hazard;
    logic            issue_fire, push_fire;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(QDEPTH));

    always_comb begin
        dec        = '0;
        legal      = 1'b0;
        uses_rs2   = 1'b0;
        dec.valid  = 1'b1;
        dec.instr  = head;
        dec.rs1    = head[19:15];
        dec.rs2    = head[24:20];
        dec.rd     = head[11:7];
        dec.funct3 = head[14:12];
        dec.funct7 = head[31:25];
        dec.order  = order_q;
        case (head[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JALR, OPC_OPIMM: begin
                legal          = 1'b1;
                dec.regwrite   = 1'b1;
                dec.alu_select = 1'b1;
            end
            OPC_JAL: begin
                legal        = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_OP: begin
                legal        = 1'b1;
                uses_rs2     = 1'b1;
                dec.regwrite = 1'b1;
            end
            OPC_LOAD: begin
                legal          = 1'b1;
                dec.regwrite   = 1'b1;
                dec.memread    = 1'b1;
                dec.wb_src     = 1'b1;
                dec.alu_select = 1'b1;
            end
            OPC_STORE: begin
                legal          = 1'b1;
                uses_rs2       = 1'b1;
                dec.memwrite   = 1'b1;
                dec.alu_select = 1'b1;
                dec.rd         = '0;
            end
            OPC_BRANCH: begin
                legal    = 1'b1;
                uses_rs2 = 1'b1;
                dec.rd   = '0;
            end
            default: legal = 1'b0;
        endcase
        dec.commit = legal;
        dec.unsign = legal && (head[14:12] == 3'b100 || head[14:12] == 3'b101);
    end

    // Load-use check against the instruction currently sitting in EX.
    assign hazard = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == dec.rs1) || (uses_rs2 && ex_q.rd == dec.rs2));

    assign issue_fire = !empty && !hazard && ex_ready && !flush;
    assign f_ready    = !full || issue_fire;
    assign push_fire  = f_valid && f_ready && !flush;

    always_comb begin
        ex_d     = ex_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        order_d  = order_q;
        if (flush) begin
            ex_d     = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (ex_ready) ex_d = issue_fire ? dec : '0;
            if (issue_fire) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                if (dec.commit) order_d = order_q + ORDER_W'(1);
            end
            if (push_fire) wr_ptr_d = wr_ptr_q + AW'(1);
            case ({push_fire, issue_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= f_instr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            order_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            order_q  <= order_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_instr      = ex_q.instr;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign ex_regwrite   = ex_q.regwrite;
    assign ex_memread    = ex_q.memread;
    assign ex_memwrite   = ex_q.memwrite;
    assign ex_alu_select = ex_q.alu_select;
    assign ex_wb_src     = ex_q.wb_src;
    assign ex_unsign     = ex_q.unsign;
    assign ex_commit     = ex_q.commit;
    assign ex_order      = ex_q.order;
    assign count         = count_q;

endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decode_queue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_instr = '0;
    logic        f_ready;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_alu_select, ex_wb_src, ex_unsign, ex_commit;
    logic [63:0] ex_order;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decode_queue_stage #(.QDEPTH(4), .ILEN(32), .ORDER_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_instr(f_instr), .f_ready(f_ready),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_alu_select(ex_alu_select), .ex_wb_src(ex_wb_src),
        .ex_unsign(ex_unsign), .ex_commit(ex_commit), .ex_order(ex_order), .count(count)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        regwrite, memread, memwrite, alu, wb, unsign, commit;
        logic [63:0] order;
    } ex_t;

    ex_t         ex_m;
    logic [31:0] q[$];
    logic [63:0] ord_m;

    function automatic ex_t model_dec(logic [31:0] ins, logic [63:0] ord);
        ex_t e = '0;
        logic [6:0] op = ins[6:0];
        bit legal = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63};
        e.valid    = 1'b1;
        e.instr    = ins;
        e.rs1      = ins[19:15];
        e.rs2      = ins[24:20];
        e.rd       = (op == 7'h23 || op == 7'h63) ? 5'd0 : ins[11:7];
        e.f3       = ins[14:12];
        e.f7       = ins[31:25];
        e.regwrite = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03};
        e.memread  = (op == 7'h03);
        e.wb       = (op == 7'h03);
        e.memwrite = (op == 7'h23);
        e.alu      = op inside {7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h67};
        e.unsign   = legal && (ins[14:12] == 3'd4 || ins[14:12] == 3'd5);
        e.commit   = legal;
        e.order    = ord;
        return e;
    endfunction

    function automatic bit reads_rs2(logic [31:0] ins);
        return ins[6:0] inside {7'h33, 7'h23, 7'h63};
    endfunction

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [132:0] dut_vec();
        return {ex_valid, ex_instr, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
                ex_regwrite, ex_memread, ex_memwrite, ex_alu_select, ex_wb_src,
                ex_unsign, ex_commit, ex_order, count, f_ready};
    endfunction

    // Compare against the model, then advance both by one clock edge.
    task automatic step();
        ex_t hd = '0;
        bit haz = 0, iss = 0, frd, psh;
        logic [31:0] pin = f_instr;
        if (q.size() > 0) begin
            hd  = model_dec(q[0], ord_m);
            haz = ex_m.valid && ex_m.memread && ex_m.rd != 0 &&
                  (ex_m.rd == hd.rs1 || (reads_rs2(q[0]) && ex_m.rd == hd.rs2));
            iss = !haz && ex_ready && !flush;
        end
        frd = (q.size() < 4) || iss;
        psh = f_valid && frd && !flush;
        chk("cycle", 160'(dut_vec()), 160'({ex_m, 3'(q.size()), frd}));
        @(posedge clk);
        if (flush) begin
            q.delete();
            ex_m = '0;
        end else begin
            if (ex_ready) ex_m = iss ? hd : '0;
            if (iss) begin
                void'(q.pop_front());
                if (hd.commit) ord_m++;
            end
            if (psh) q.push_back(pin);
        end
        @(negedge clk);
    endtask

    task automatic cyc(bit fv, logic [31:0] ins, bit er, bit fl);
        f_valid  = fv;
        f_instr  = ins;
        ex_ready = er;
        flush    = fl;
        #1;
        step();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic hard_reset(string nm);
        rst_n = 1'b0;
        #1;
        chk({nm, "_async_clear"}, 160'(dut_vec()), 160'd1);
        q.delete();
        ex_m  = '0;
        ord_m = '0;
        f_valid = 0; flush = 0; ex_ready = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] addi(int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h7F};
        logic [6:0] op = ops[$urandom_range(0, 9)];
        return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), op};
    endfunction

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADD  = 32'h001101B3;
    localparam logic [31:0] I_BEQ  = 32'h00210463;
    localparam logic [31:0] I_SW   = 32'h00202023;

    initial begin
        ex_m  = '0;
        ord_m = '0;
        @(negedge clk);
        hard_reset("reset");
        chk("reset_f_ready", 160'(f_ready), 160'd1);

        // addi issues one cycle after its push
        cyc(1, I_ADDI, 1, 0);
        cyc(0, 0, 1, 0);
        chk("addi_fields", 160'({ex_valid, ex_rd, ex_regwrite, ex_alu_select, ex_commit}),
            160'({1'b1, 5'd1, 1'b1, 1'b1, 1'b1}));
        chk("addi_order", 160'(ex_order), 160'd0);

        // load-use on rs1: one bubble, then add with order 1
        hard_reset("lw_add");
        cyc(1, I_LW, 1, 0);
        cyc(1, I_ADD, 1, 0);
        chk("lw_issue", 160'({ex_valid, ex_memread, ex_wb_src, ex_rd}), 160'({3'b111, 5'd2}));
        cyc(0, 0, 1, 0);
        chk("lw_add_bubble", 160'({ex_valid, count}), 160'({1'b0, 3'd1}));
        cyc(0, 0, 1, 0);
        chk("add_issue", 160'({ex_valid, ex_rd, ex_order}), 160'({1'b1, 5'd3, 64'd1}));

        // branch stalls behind lw, store reports rd 0
        hard_reset("lw_beq");
        cyc(1, I_LW, 1, 0);
        cyc(1, I_BEQ, 1, 0);
        cyc(1, I_SW, 1, 0);
        chk("beq_stall", 160'({ex_valid, count}), 160'({1'b0, 3'd2}));
        cyc(0, 0, 1, 0);
        chk("beq_issue", 160'({ex_valid, ex_rd, ex_regwrite, ex_instr}), 160'({1'b1, 5'd0, 1'b0, I_BEQ}));
        cyc(0, 0, 1, 0);
        chk("sw_issue", 160'({ex_valid, ex_rd, ex_memwrite, ex_alu_select}), 160'({1'b1, 5'd0, 1'b1, 1'b1}));

        // fill to capacity, then simultaneous push and pop while full
        hard_reset("full");
        for (int k = 1; k <= 4; k++) cyc(1, addi(k), 0, 0);
        chk("full_count", 160'(count), 160'd4);
        f_valid = 1; f_instr = addi(5); ex_ready = 0; #1;
        chk("full_not_ready", 160'(f_ready), 160'd0);
        step();
        ex_ready = 1; #1;
        chk("full_pushpop_ready", 160'(f_ready), 160'd1);
        step();
        chk("full_pushpop", 160'({count, ex_instr}), 160'({3'd4, addi(1)}));
        for (int k = 2; k <= 5; k++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("drain_%0d", k), 160'(ex_instr), 160'(addi(k)));
        end

        // flush drops queue, ID/EX and the concurrent fetch, keeps order counter
        hard_reset("flush");
        cyc(1, addi(1), 1, 0);
        cyc(0, 0, 1, 0);
        for (int k = 2; k <= 4; k++) cyc(1, addi(k), 0, 0);
        chk("pre_flush_count", 160'(count), 160'd3);
        cyc(1, addi(9), 0, 1);
        chk("post_flush", 160'({count, ex_valid}), 160'({3'd0, 1'b0}));
        cyc(1, addi(6), 1, 0);
        cyc(0, 0, 1, 0);
        chk("post_flush_order", 160'({ex_instr, ex_order}), 160'({addi(6), 64'd1}));

        // illegal opcode issues as a non-committing instruction
        cyc(1, 32'hFFFFFFFF, 1, 0);
        cyc(0, 0, 1, 0);
        chk("illegal_ctrl", 160'({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alu_select,
                                  ex_wb_src, ex_unsign, ex_commit}), 160'(8'b1000_0000));
        chk("illegal_order", 160'(ex_order), 160'd2);
        cyc(1, addi(7), 1, 0);
        cyc(0, 0, 1, 0);
        chk("after_illegal_order", 160'(ex_order), 160'd2);

        // randomized traffic with a mid-stream asynchronous reset
        for (int i = 0; i < 800; i++) begin
            if (i == 400) hard_reset("mid_stream");
            cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
